// File: rtl/chan_scan_mux.sv
// chan_scan_mux: registered CHANNELS:1 multiplexer with a manual select mode
// and a scan mode that walks an enable mask, holding each channel for
// dwell+1 cycles and pulsing wrap whenever the scan returns to a lower or
// equal channel index.
module chan_scan_mux #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3,
    parameter int DWELL_W  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel_in,
    input  logic                      start,
    input  logic [CHANNELS-1:0]       en_mask,
    input  logic [DWELL_W-1:0]        dwell,
    output logic [WIDTH-1:0]          y,
    output logic [SEL_W-1:0]          sel_out,
    output logic                      valid,
    output logic                      wrap
);

    typedef enum logic [1:0] {IDLE, MAN, SCAN} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               valid_q, valid_d;
    logic               wrap_q, wrap_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;

    // Unpack the flat input bus into one word per channel.
    logic [WIDTH-1:0] ch [CHANNELS];
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_unpack
        assign ch[gi] = din[gi*WIDTH +: WIDTH];
    end

    logic               mask_any;
    logic               man_hit;
    logic               next_above;
    logic [SEL_W-1:0]   first_sel;
    logic [SEL_W-1:0]   next_sel;
    logic [SEL_W-1:0]   adv_sel;
    logic [WIDTH-1:0]   man_y;
    logic [WIDTH-1:0]   cur_y;
    logic [WIDTH-1:0]   first_y;
    logic [WIDTH-1:0]   adv_y;

    // Channel lookups: manual pick, current channel, first enabled channel
    // and the channel an advance would move to. Descending loops leave the
    // lowest qualifying index as the final assignment.
    always_comb begin
        mask_any   = |en_mask;
        man_hit    = 1'b0;
        man_y      = '0;
        cur_y      = '0;
        first_sel  = '0;
        next_sel   = '0;
        next_above = 1'b0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (sel_in == SEL_W'(k)) begin
                man_y   = ch[k];
                man_hit = 1'b1;
            end
            if (sel_q == SEL_W'(k)) begin
                cur_y = ch[k];
            end
            if (en_mask[k]) begin
                first_sel = SEL_W'(k);
                if (SEL_W'(k) > sel_q) begin
                    next_sel   = SEL_W'(k);
                    next_above = 1'b1;
                end
            end
        end
        if (!next_above) begin
            next_sel = first_sel;
        end
        // Resuming after an empty-mask stall restarts from the first channel.
        adv_sel = valid_q ? next_sel : first_sel;
        first_y = '0;
        adv_y   = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (first_sel == SEL_W'(k)) begin
                first_y = ch[k];
            end
            if (adv_sel == SEL_W'(k)) begin
                adv_y = ch[k];
            end
        end
    end

    // Next-state and output-register logic for the IDLE/MAN/SCAN sequencer.
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        wrap_d  = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (!mode) begin
                    state_d = MAN;
                end else if (start && mask_any) begin
                    state_d = SCAN;
                    sel_d   = first_sel;
                    y_d     = first_y;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            MAN: begin
                if (mode) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end else begin
                    sel_d   = sel_in;
                    y_d     = man_y;
                    valid_d = man_hit;
                end
            end
            SCAN: begin
                if (!mode) begin
                    state_d = MAN;
                    sel_d   = sel_in;
                    y_d     = man_y;
                    valid_d = man_hit;
                end else if (start) begin
                    if (mask_any) begin
                        sel_d   = first_sel;
                        y_d     = first_y;
                        valid_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end
                end else if (cnt_q == dwell) begin
                    cnt_d = '0;
                    if (!mask_any) begin
                        valid_d = 1'b0;
                    end else begin
                        sel_d   = adv_sel;
                        y_d     = adv_y;
                        valid_d = 1'b1;
                        wrap_d  = valid_q && (next_sel <= sel_q);
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (valid_q) begin
                        y_d = cur_y;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            y_q     <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
        end
    end

    assign y       = y_q;
    assign sel_out = sel_q;
    assign valid   = valid_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_chan_scan_mux.sv
// Testbench for chan_scan_mux: directed steps plus a randomized phase, all
// checked against a behavioural model built from an enabled-channel list.
module tb_chan_scan_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] din;
    logic        mode;
    logic [2:0]  sel_in;
    logic        start;
    logic [7:0]  en_mask;
    logic [3:0]  dwell;
    logic [3:0]  y;
    logic [2:0]  sel_out;
    logic        valid;
    logic        wrap;
    logic [3:0]  y6;
    logic [2:0]  sel6;
    logic        valid6;
    logic        wrap6;

    int n_checks = 0;
    int n_fail   = 0;

    // model state: 0 idle, 1 manual, 2 scan
    int st, m_sel, m_y, m_valid, m_wrap, m_cnt;

    always #5 clk = ~clk;

    chan_scan_mux #(.WIDTH(4), .CHANNELS(8), .SEL_W(3), .DWELL_W(4)) dut (
        .clk(clk), .rst(rst), .din(din), .mode(mode), .sel_in(sel_in),
        .start(start), .en_mask(en_mask), .dwell(dwell),
        .y(y), .sel_out(sel_out), .valid(valid), .wrap(wrap)
    );

    chan_scan_mux #(.WIDTH(4), .CHANNELS(6), .SEL_W(3), .DWELL_W(4)) dut6 (
        .clk(clk), .rst(rst), .din(din[23:0]), .mode(mode), .sel_in(sel_in),
        .start(start), .en_mask(en_mask[5:0]), .dwell(dwell),
        .y(y6), .sel_out(sel6), .valid(valid6), .wrap(wrap6)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int chan(input int k);
        return int'(din[k*4 +: 4]);
    endfunction

    task automatic model_reset();
        st = 0; m_sel = 0; m_y = 0; m_valid = 0; m_wrap = 0; m_cnt = 0;
    endtask

    task automatic model_manual();
        m_sel  = int'(sel_in);
        m_wrap = 0;
        m_y    = chan(m_sel);
        m_valid = 1;
    endtask

    // Model one rising edge using the inputs present at that edge.
    task automatic model_edge();
        int q[$];
        int nx;
        for (int k = 0; k < 8; k++) if (en_mask[k]) q.push_back(k);
        m_wrap = 0;
        if (st == 0) begin
            m_valid = 0;
            if (!mode) st = 1;
            else if (start && q.size() > 0) begin
                st = 2; m_sel = q[0]; m_y = chan(q[0]); m_valid = 1; m_cnt = 0;
            end
        end else if (st == 1) begin
            if (mode) begin st = 0; m_valid = 0; end
            else model_manual();
        end else begin
            if (!mode) begin
                st = 1; model_manual();
            end else if (start) begin
                if (q.size() > 0) begin
                    m_sel = q[0]; m_y = chan(q[0]); m_valid = 1; m_cnt = 0;
                end else begin
                    st = 0; m_valid = 0;
                end
            end else if (m_cnt == int'(dwell)) begin
                m_cnt = 0;
                if (q.size() == 0) m_valid = 0;
                else if (m_valid == 0) begin
                    m_sel = q[0]; m_y = chan(q[0]); m_valid = 1;
                end else begin
                    nx = q[0];
                    foreach (q[i]) if (q[i] > m_sel) begin nx = q[i]; break; end
                    m_wrap = (nx <= m_sel) ? 1 : 0;
                    m_sel = nx; m_y = chan(nx);
                end
            end else begin
                m_cnt = (m_cnt + 1) % 16;
                if (m_valid == 1) m_y = chan(m_sel);
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".y"},     32'(y),       32'(m_y));
        chk({tag, ".sel"},   32'(sel_out), 32'(m_sel));
        chk({tag, ".valid"}, 32'(valid),   32'(m_valid));
        chk({tag, ".wrap"},  32'(wrap),    32'(m_wrap));
    endtask

    // One clock edge: update the model, then compare 1 time unit later.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        $display("[%0t] %-10s mode=%0b start=%0b mask=%02h dwell=%0d sel=%0d y=%0h valid=%0b wrap=%0b",
                 $time, tag, mode, start, en_mask, dwell, sel_out, y, valid, wrap);
        check_model(tag);
    endtask

    initial begin
        int n;
        logic [3:0] nv;
        rst = 1'b1; din = 32'h8765_4321; mode = 1'b0; sel_in = '0;
        start = 1'b0; en_mask = '0; dwell = '0;
        model_reset();
        #1;
        check_model("reset");
        #11;
        rst = 1'b0;

        // Manual sweep, both widths of mux
        step("idle2man");
        for (int s = 0; s < 8; s++) begin
            sel_in = 3'(s);
            step("man");
            chk("man.y", 32'(y), 32'(s + 1));
            chk("man6.y", 32'(y6), (s < 6) ? 32'(s + 1) : 32'd0);
            chk("man6.valid", 32'(valid6), (s < 6) ? 32'd1 : 32'd0);
            chk("man6.sel", 32'(sel6), 32'(s));
        end

        // Full mask, dwell 0
        mode = 1'b1;
        step("man2idle");
        start = 1'b1; en_mask = 8'hFF; dwell = 4'd0; din = $urandom;
        step("fullstart");
        chk("full.sel0", 32'(sel_out), 32'd0);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            din = $urandom;
            step("full");
            chk("full.seq", 32'(sel_out), 32'((i + 1) % 8));
            chk("full.wrap", 32'(wrap), (i == 7) ? 32'd1 : 32'd0);
        end

        // Sparse mask with dwell 2 and a mid-dwell data change on channel 5
        start = 1'b1; en_mask = 8'b1010_0100; dwell = 4'd2;
        step("sparse0");
        chk("sparse.seq", 32'(sel_out), 32'd2);
        start = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            int exp_sel;
            exp_sel = (i < 3) ? 2 : (i < 6) ? 5 : (i < 9) ? 7 : 2;
            if (i == 4) begin
                nv = ~din[23:20];
                din[23:20] = nv;
            end
            step("sparse");
            chk("sparse.seq", 32'(sel_out), 32'(exp_sel));
            chk("sparse.wrap", 32'(wrap), (i == 9) ? 32'd1 : 32'd0);
            if (i == 4) chk("sparse.live", 32'(y), 32'(nv));
        end

        // Empty mask at start: back to IDLE, nothing valid
        en_mask = 8'h00; start = 1'b1;
        step("empty");
        step("empty");
        chk("empty.valid", 32'(valid), 32'd0);

        // Single enabled channel, dwell 1
        en_mask = 8'b0001_0000; dwell = 4'd1;
        step("single0");
        start = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step("single");
            chk("single.sel", 32'(sel_out), 32'd4);
            chk("single.wrap", 32'(wrap), (i % 2 == 0) ? 32'd1 : 32'd0);
        end

        // Mask cleared mid-scan, then restored
        en_mask = 8'b0110_0000; start = 1'b1;
        step("mclr0");
        start = 1'b0;
        step("mclr");
        en_mask = 8'h00;
        step("mclr");
        chk("mclr.valid", 32'(valid), 32'd0);
        chk("mclr.hold", 32'(sel_out), 32'd5);
        step("mclr");
        step("mclr");
        en_mask = 8'b0110_0000;
        step("mrst");
        step("mrst");
        chk("mrst.valid", 32'(valid), 32'd1);
        chk("mrst.sel", 32'(sel_out), 32'd5);

        // Dwell shortened below the running count
        en_mask = 8'hFF; dwell = 4'd8; start = 1'b1;
        step("dw0");
        start = 1'b0;
        for (int i = 0; i < 5; i++) step("dw");
        dwell = 4'd2;
        n = 0;
        while (sel_out == 3'd0 && n < 40) begin
            step("dwshort");
            n++;
        end
        chk("dw.advance_edge", 32'(n), 32'd14);

        // Leaving scan for manual applies the manual pick on the same edge
        mode = 1'b0; sel_in = 3'd3;
        step("scan2man");
        chk("s2m.y", 32'(y), 32'(din[15:12]));
        chk("s2m.valid", 32'(valid), 32'd1);

        // Reset mid-scan
        mode = 1'b1;
        step("toidle");
        start = 1'b1; dwell = 4'd3;
        step("rs0");
        start = 1'b0;
        step("rs");
        step("rs");
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_model("asyncrst");
        #3 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step("nostart");
            chk("nostart.valid", 32'(valid), 32'd0);
        end

        // Randomized phase
        for (int i = 0; i < 120; i++) begin
            din    = $urandom;
            mode   = ($urandom_range(0, 11) != 0);
            start  = ($urandom_range(0, 9) == 0);
            sel_in = 3'($urandom);
            if ($urandom_range(0, 5) == 0) en_mask = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 7) == 0) dwell = 4'($urandom_range(0, 3));
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/chan_scan_mux.md
# chan_scan_mux

Parameterised CHANNELS:1 multiplexer with registered output and a built-in channel sequencer. It is the next generation of the team's fixed 8:1 and 4:1 mux blocks. In manual mode it is a one-cycle-latency registered N:1 mux. In scan mode it steps through an enable mask of channels, holding each for a programmable dwell time and flagging every wrap-around. It feeds shared downstream logic (display, ADC front-end, serialiser) from many same-width sources.

## Interface
- WIDTH, 4, data bits per channel
- CHANNELS, 8, number of input channels (≥2)
- SEL_W, 3, select width; must satisfy 2**SEL_W ≥ CHANNELS
- DWELL_W, 4, dwell counter width
- clk  input  1  single clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- din  input  CHANNELS*WIDTH  packed inputs; channel k = din[k*WIDTH +: WIDTH]
- mode  input  1  0 = manual select, 1 = scan
- sel_in  input  SEL_W  manual channel select
- start  input  1  scan start/restart strobe, sampled when mode=1
- en_mask  input  CHANNELS  scan enable per channel, bit k = channel k
- dwell  input  DWELL_W  extra cycles each channel is held (0 = advance every cycle)
- y  output  WIDTH  registered selected data
- sel_out  output  SEL_W  channel currently driving y
- valid  output  1  y/sel_out are meaningful
- wrap  output  1  one-cycle pulse when scan wraps to a lower-or-equal index

## Operation
- States: IDLE, MAN, SCAN. Reset state is IDLE.
- Reset (async, immediate) sets y=0, sel_out=0, valid=0, wrap=0, and dwell count cnt=0.
- The "first" channel is the lowest set bit of en_mask. The "next after c" channel is the lowest set bit above c; if there is none, it is the lowest set bit overall (a wrap).
- IDLE:
  - valid=0; y and sel_out hold.
  - mode=0 → MAN.
  - mode=1 with start=1 → SCAN.
  - mode=1 with start=0 → stay in IDLE.
- MAN:
  - Each edge: y<=channel sel_in, sel_out<=sel_in, valid<=1.
  - sel_in ≥ CHANNELS: y<=0, valid<=0, sel_out<=sel_in.
  - mode=1 → IDLE (valid<=0) to wait for start.
- Entering SCAN (start edge):
  - Mask non-zero: sel_out<=first, y<=din[first], valid<=1, cnt<=0, wrap<=0.
  - Mask all zero: valid<=0 and the block stays in IDLE.
- SCAN, each edge:
  - mode=0 → MAN, and the manual update happens on that same edge.
  - start=1 → restart exactly as on entry.
  - cnt==dwell → advance: cnt<=0, sel_out<=next, y<=din[next], wrap<=1 iff next ≤ current sel_out.
  - Otherwise: cnt<=cnt+1, y<=din[sel_out] (live refresh), wrap<=0.
- Mask rules:
  - en_mask is evaluated only at advance/entry. Clearing the current channel's bit takes effect at its next advance.
  - If the mask is all zero at an advance: valid<=0, sel_out and y hold, cnt<=0. The block retries every dwell+1 cycles. Scanning resumes, with valid<=1, at the first advance that sees a non-zero mask; wrap<=0 on that advance.
- Single enabled channel: every advance re-selects the same channel with wrap=1.
- dwell is sampled on every compare, so a change mid-dwell applies immediately.
  - Case 1: the new dwell ≤ cnt. The compare cnt==dwell does not match, so cnt keeps incrementing, wraps modulo 2**DWELL_W and advances when it next reaches dwell. This is defined behaviour; the bench checks it.
  - Case 2: the new dwell > cnt. The advance happens when cnt reaches the new value.
- wrap is 0 in every state except on a SCAN advance.

## Timing
- Manual latency: 1 cycle from sel_in/din change to y.
- Scan: each channel is presented for exactly dwell+1 cycles. The full period is popcount(en_mask)*(dwell+1) cycles.
- First scanned data appears on the start edge. The wrap pulse coincides with the cycle in which sel_out shows the wrapped channel.
- Reset asserted mid-scan clears the outputs asynchronously. After release the block is in IDLE and needs a new start.
- start and mode=0 together: mode=0 wins.

## Test plan
- Manual sweep: CHANNELS=8, WIDTH=4, din channel k = k+1, sel_in 0..7, one per cycle → y = sel_in+1 one cycle later, valid=1. Then sel_in=7 with CHANNELS=6 → y=0, valid=0.
- Scan, full mask: en_mask=8'hFF, dwell=0, start → sel_out 0,1,...,7,0 on consecutive cycles. wrap=1 only on the cycle sel_out returns to 0.
- Sparse mask and dwell:
  - en_mask=8'b1010_0100, dwell=2 → sel_out 2,2,2,5,5,5,7,7,7,2 with wrap at the return to 2.
  - Changing din[5] mid-dwell → y follows within 1 cycle.
- Mask edge cases:
  - en_mask=0 at start → valid=0, block stays in IDLE.
  - en_mask=8'b0001_0000 → sel_out stays 4 with wrap=1 every dwell+1 cycles.
  - Mask cleared to 0 mid-scan, then restored → at the next advance valid=0 and sel_out/y hold; at the first advance after restore valid=1 and sel_out=first.
- Dwell shortened mid-count: dwell=8, reach cnt=5, set dwell=2 → no advance at cnt=5; cnt increments to 15 (DWELL_W=4), wraps to 0 and the advance occurs at cnt=2.
- Mode/reset: mode 1→0 mid-scan → manual output on the same edge. rst pulse mid-scan → y=0, valid=0, wrap=0 immediately; after release mode=1 without start → valid stays 0.
